// File: rtl/mem_stage.sv
//----------------------------------------------------------------------------
// mem_stage : MIPS MEM stage; holds one instr, waits on data SRAM for loads.
// Optional MS_FWD_EN adds forwarding/load-block outputs.   Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 71
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif

module mem_stage #(
  parameter int LD_TIMEOUT = 255,
  parameter int CNT_WD     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ws_allowin,
  output logic                        ms_allowin,
  input  logic                        es_to_ms_valid,
  input  logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                        ms_to_ws_valid,
  output logic [`MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                        cpu_data_ok,
  input  logic [31:0]                 cpu_data_rdata,
`ifdef MS_FWD_EN
  output logic [38:0]                 ms_fwd_bus,
  output logic                        ms_ld_blk,
`endif
  output logic                        ms_ld_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [CNT_WD-1:0] TIMEOUT_CNT = CNT_WD'(LD_TIMEOUT);
  localparam int                LOAD_BIT    = 38;

  state_e                      state_q, state_d;
  logic                        ms_valid_q, ms_valid_d;
  logic [CNT_WD-1:0]           cnt_q, cnt_d;
  logic [31:0]                 rdata_buf_q, rdata_buf_d;
  logic [`ES_TO_MS_BUS_WD-1:0] es_bus_q, es_bus_d;
  logic                        ld_err_q, ld_err_d;

  logic [31:0] pc;
  logic        load_op;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic        ms_ready_go;
  logic        timeout;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign {pc, load_op, rf_we, rf_waddr, alu_result} = es_bus_q;

  // Response is only consumed in WAIT; elsewhere cpu_data_ok has no effect.
  always_comb begin
    timeout     = (state_q == S_WAIT) && (cnt_q == TIMEOUT_CNT) && !cpu_data_ok;
    ms_ready_go = 1'b1;
    load_result = 32'h0;
    if (load_op) begin
      case (state_q)
        S_WAIT: begin
          ms_ready_go = cpu_data_ok | timeout;
          load_result = cpu_data_ok ? cpu_data_rdata : 32'h0;
        end
        S_HOLD: begin
          ms_ready_go = 1'b1;
          load_result = rdata_buf_q;
        end
        default: begin
          ms_ready_go = 1'b1;
          load_result = 32'h0;
        end
      endcase
    end
    final_result   = load_op ? load_result : alu_result;
    ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid_q && ms_ready_go;
    ms_to_ws_bus   = {pc, rf_we, rf_waddr, final_result};
    ms_ld_err      = ld_err_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_buf_d = rdata_buf_q;
    es_bus_d    = es_bus_q;
    ms_valid_d  = ms_allowin ? es_to_ms_valid : ms_valid_q;
    ld_err_d    = ld_err_q | (ms_valid_q & load_op & timeout);
    if (ms_allowin && es_to_ms_valid) begin
      es_bus_d = es_to_ms_bus;
    end
    if (ms_allowin) begin
      // Handoff: a new load enters WAIT with a fresh counter, buffer untouched.
      cnt_d   = '0;
      state_d = (es_to_ms_valid && es_to_ms_bus[LOAD_BIT]) ? S_WAIT : S_IDLE;
    end else if (ms_valid_q && load_op && (state_q == S_WAIT)) begin
      if (ms_ready_go) begin
        state_d     = S_HOLD;
        rdata_buf_d = final_result;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ms_valid_q  <= 1'b0;
      cnt_q       <= '0;
      rdata_buf_q <= 32'h0;
      es_bus_q    <= '0;
      ld_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_valid_q  <= ms_valid_d;
      cnt_q       <= cnt_d;
      rdata_buf_q <= rdata_buf_d;
      es_bus_q    <= es_bus_d;
      ld_err_q    <= ld_err_d;
    end
  end

`ifdef MS_FWD_EN
  always_comb begin
    ms_fwd_bus = {ms_valid_q & rf_we, rf_waddr, final_result};
    ms_ld_blk  = ms_valid_q & load_op & ~ms_ready_go;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//----------------------------------------------------------------------------
// tb_mem_stage : directed self-checking bench for mem_stage (LD_TIMEOUT=4).
//----------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [70:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        cpu_data_ok;
  logic [31:0] cpu_data_rdata;
  logic        ms_ld_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.LD_TIMEOUT(4), .CNT_WD(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .ws_allowin     (ws_allowin),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .cpu_data_ok    (cpu_data_ok),
    .cpu_data_rdata (cpu_data_rdata),
    .ms_ld_err      (ms_ld_err)
  );

  function automatic logic [70:0] es(input logic [31:0] pc, input logic ld,
                                     input logic we, input logic [4:0] wa,
                                     input logic [31:0] alu);
    return {pc, ld, we, wa, alu};
  endfunction

  function automatic logic [69:0] ws(input logic [31:0] pc, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res);
    return {pc, we, wa, res};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
    cpu_data_ok    = 1'b0;
    cpu_data_rdata = '0;
    #2;
    chk("rst_valid",   ms_to_ws_valid, 0);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_err",     ms_ld_err, 0);
    chk("rst_bus",     ms_to_ws_bus, 0);
    tick();
    reset = 1'b1;

    // ALU instruction passes through in one cycle
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es(32'hBFC00000, 1'b0, 1'b1, 5'd5, 32'h12345678);
    #2 chk("alu_allowin_in", ms_allowin, 1);
    tick();
    es_to_ms_valid = 1'b0;
    #2;
    chk("alu_valid", ms_to_ws_valid, 1);
    chk("alu_bus",   ms_to_ws_bus, ws(32'hBFC00000, 1'b1, 5'd5, 32'h12345678));
    tick();
    chk("alu_drain", ms_to_ws_valid, 0);

    // Load answered in first MEM cycle: no stall
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es(32'hBFC00004, 1'b1, 1'b1, 5'd8, 32'h00001000);
    tick();
    es_to_ms_valid = 1'b0;
    cpu_data_ok    = 1'b1;
    cpu_data_rdata = 32'hDEADBEEF;
    #2;
    chk("ld1_valid",   ms_to_ws_valid, 1);
    chk("ld1_bus",     ms_to_ws_bus, ws(32'hBFC00004, 1'b1, 5'd8, 32'hDEADBEEF));
    chk("ld1_allowin", ms_allowin, 1);
    tick();
    cpu_data_ok = 1'b0;
    #2 chk("ld1_drain", ms_to_ws_valid, 0);

    // Load answered after 3 wait cycles
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es(32'hBFC00008, 1'b1, 1'b1, 5'd9, 32'h00002000);
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("ld3_stall_allowin", ms_allowin, 0);
      chk("ld3_stall_valid",   ms_to_ws_valid, 0);
      tick();
    end
    cpu_data_ok    = 1'b1;
    cpu_data_rdata = 32'hCAFEF00D;
    #2;
    chk("ld3_valid", ms_to_ws_valid, 1);
    chk("ld3_bus",   ms_to_ws_bus, ws(32'hBFC00008, 1'b1, 5'd9, 32'hCAFEF00D));
    tick();
    cpu_data_ok = 1'b0;

    // Data arriving in the very cycle the counter hits the limit wins
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es(32'hBFC0000C, 1'b1, 1'b0, 5'd3, 32'h0);
    tick();
    es_to_ms_valid = 1'b0;
    repeat (4) tick();
    cpu_data_ok    = 1'b1;
    cpu_data_rdata = 32'hA5A5A5A5;
    #2;
    chk("race_valid", ms_to_ws_valid, 1);
    chk("race_bus",   ms_to_ws_bus, ws(32'hBFC0000C, 1'b0, 5'd3, 32'hA5A5A5A5));
    tick();
    cpu_data_ok = 1'b0;
    #2 chk("race_no_err", ms_ld_err, 0);

    // Load completes under WB backpressure, spurious data_ok in HOLD
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es(32'hBFC00010, 1'b1, 1'b1, 5'd10, 32'h0);
    tick();
    es_to_ms_valid = 1'b0;
    cpu_data_ok    = 1'b1;
    cpu_data_rdata = 32'h11223344;
    #2;
    chk("hold_first_bus",     ms_to_ws_bus, ws(32'hBFC00010, 1'b1, 5'd10, 32'h11223344));
    chk("hold_first_allowin", ms_allowin, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      cpu_data_ok    = 1'b1;
      cpu_data_rdata = 32'h00000001;
      #2;
      chk("hold_valid", ms_to_ws_valid, 1);
      chk("hold_bus",   ms_to_ws_bus, ws(32'hBFC00010, 1'b1, 5'd10, 32'h11223344));
    end
    tick();
    cpu_data_ok    = 1'b0;
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es(32'hBFC00014, 1'b1, 1'b1, 5'd11, 32'h0);
    #2;
    chk("hold_release_bus",     ms_to_ws_bus, ws(32'hBFC00010, 1'b1, 5'd10, 32'h11223344));
    chk("hold_release_allowin", ms_allowin, 1);
    tick();
    es_to_ms_valid = 1'b0;
    #2;
    chk("b2b_wait_valid",   ms_to_ws_valid, 0);
    chk("b2b_wait_allowin", ms_allowin, 0);
    tick();
    cpu_data_ok    = 1'b1;
    cpu_data_rdata = 32'h00000055;
    #2 chk("b2b_bus", ms_to_ws_bus, ws(32'hBFC00014, 1'b1, 5'd11, 32'h00000055));
    tick();
    cpu_data_ok = 1'b0;

    // Timeout: no data_ok at all
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es(32'hBFC00018, 1'b1, 1'b1, 5'd12, 32'h0);
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("to_wait_valid", ms_to_ws_valid, 0);
      chk("to_wait_err",   ms_ld_err, 0);
      tick();
    end
    #2;
    chk("to_valid", ms_to_ws_valid, 1);
    chk("to_bus",   ms_to_ws_bus, ws(32'hBFC00018, 1'b1, 5'd12, 32'h0));
    tick();
    chk("to_err", ms_ld_err, 1);
    chk("to_drain", ms_to_ws_valid, 0);
    repeat (3) tick();
    chk("to_err_sticky", ms_ld_err, 1);

    // Reset asserted mid-WAIT
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es(32'hBFC0001C, 1'b1, 1'b1, 5'd13, 32'h0);
    tick();
    es_to_ms_valid = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("rstw_valid",   ms_to_ws_valid, 0);
    chk("rstw_allowin", ms_allowin, 1);
    chk("rstw_err",     ms_ld_err, 0);
    tick();
    cpu_data_ok    = 1'b1;
    cpu_data_rdata = 32'h00000077;
    #1 reset = 1'b1;
    #1 chk("rstw_late_ok", ms_to_ws_valid, 0);
    tick();
    chk("rstw_late_ok2", ms_to_ws_valid, 0);
    cpu_data_ok = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
